// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// The MDU_DIV_EN macro (see mdu.sv) decides whether the divide path is built.
package mdu_pkg;

  localparam int unsigned MDU_DEFAULT_N = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_t;

endpackage

// File: rtl/au.sv
// Add/subtract unit used for one multiply or divide iteration.
module au #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s
);

  assign s = sub ? (x - y) : (x + y);

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers and N-cycle radix-2 datapath.
// Define MDU_DIV_EN to build the restoring divider; without it divide requests are ignored.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned N = MDU_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         div,
  input  logic         u,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int unsigned CW = $clog2(N);

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  acc_q, q_q, mb_q, hi_q, lo_q;
  logic          op_div_q, neg_q, neg_r_q, dz_op_q, done_q, dz_q;

  logic          accept, sa, sb;
  logic [N-1:0]  ma, mb;
  logic [N:0]    au_x, au_y, au_s;
  logic [2*N-1:0] prod, prod_fix;

  assign accept = (state_q == IDLE) && start && (!div || DivEn);
  assign sa     = !u && a[N-1];
  assign sb     = !u && b[N-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;

  // Divide feeds the partial remainder shifted left by one dividend bit.
  assign au_x = op_div_q ? {acc_q, q_q[N-1]} : {1'b0, acc_q};
  assign au_y = {1'b0, mb_q};

  au #(
    .W (N + 1)
  ) u_au (
    .x   (au_x),
    .y   (au_y),
    .sub (op_div_q),
    .s   (au_s)
  );

  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_q ? -prod : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      mb_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_op_q  <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (accept) begin
            op_div_q <= div && DivEn;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= ma;
            mb_q     <= mb;
            neg_q    <= sa ^ sb;
            neg_r_q  <= sa;
            dz_op_q  <= div && DivEn && (b == '0);
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_div_q) begin
            // A clear borrow bit means the trial subtraction fits.
            if (!au_s[N]) begin
              acc_q <= au_s[N-1:0];
              q_q   <= {q_q[N-2:0], 1'b1};
            end else begin
              acc_q <= {acc_q[N-2:0], q_q[N-1]};
              q_q   <= {q_q[N-2:0], 1'b0};
            end
          end else if (q_q[0]) begin
            acc_q <= au_s[N:1];
            q_q   <= {au_s[0], q_q[N-1:1]};
          end else begin
            acc_q <= {1'b0, acc_q[N-1:1]};
            q_q   <= {acc_q[0], q_q[N-1:1]};
          end
        end
        FIX: begin
          if (op_div_q) begin
            lo_q <= dz_op_q ? '1 : (neg_q ? -q_q : q_q);
            hi_q <= neg_r_q ? -acc_q : acc_q;
            dz_q <= dz_op_q;
          end else begin
            {hi_q, lo_q} <= prod_fix;
            dz_q         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign dz   = dz_q && DivEn;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops against an arithmetic model.
module tb_mdu;

  localparam int N = 32;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, div = 1'b0, u = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [N-1:0] a = '0, b = '0, wdata = '0;
  logic [N-1:0] hi, lo;
  logic         busy, done, dz;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  mdu #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .div   (div),
    .u     (u),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    cmp_cnt++;
    assert (obs === want)
    else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input bit d, input bit uu, input logic [31:0] aa,
                                input logic [31:0] bb, output logic [31:0] eh,
                                output logic [31:0] el, output bit edz);
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ua = {32'h0, aa};
    ub = {32'h0, bb};
    edz = 1'b0;
    if (!d) begin
      if (uu) begin
        ur = ua * ub;
        {eh, el} = ur;
      end else begin
        r = sa * sb;
        {eh, el} = r;
      end
    end else if (bb == 32'h0) begin
      el = 32'hFFFF_FFFF;
      eh = aa;
      edz = 1'b1;
    end else if (uu) begin
      ur = ua / ub;
      el = ur[31:0];
      ur = ua % ub;
      eh = ur[31:0];
    end else begin
      r = sa / sb;
      el = r[31:0];
      r = sa % sb;
      eh = r[31:0];
    end
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic run_op(input bit d, input bit uu, input logic [31:0] aa,
                        input logic [31:0] bb, input string tag);
    logic [31:0] eh, el;
    bit edz;
    int lat;
    model(d, uu, aa, bb, eh, el, edz);
    @(negedge clk);
    start = 1'b1; div = d; u = uu; a = aa; b = bb;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    bit d, uu;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_flags", {61'd0, busy, done, dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");

`ifdef MDU_DIV_EN
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, "divu");
    run_op(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0000, "divu_dz");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
`else
    @(negedge clk);
    start = 1'b1; div = 1'b1; u = 1'b1; a = 32'h7; b = 32'h0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("nodiv_busy", 64'(busy), 64'd0);
    watch_no_done("nodiv_done", 40);
    chk("nodiv_dz", 64'(dz), 64'd0);
`endif

    // MTHI / MTLO in idle
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234_5678);
    chk("mtlo", 64'(lo), 64'h9ABC_DEF0);

    // Writes and a second start while busy are ignored
    @(negedge clk);
    start = 1'b1; div = 1'b0; u = 1'b1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd100;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_hi_hold", 64'(hi), 64'h1234_5678);
    chk("busy_lo_hold", 64'(lo), 64'h9ABC_DEF0);
    wait_done(lat);
    chk("busy_op_lo", 64'(lo), 64'd42);
    chk("busy_op_hi", 64'(hi), 64'd0);
    watch_no_done("no_second_done", 40);

    // Same-cycle MTHI with an accepted start
    @(negedge clk);
    start = 1'b1; div = 1'b0; u = 1'b1; a = 32'd2; b = 32'd3;
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("samecyc_hi", 64'(hi), 64'hCAFE_F00D);
    wait_done(lat);
    chk("samecyc_lat", 64'(lat), 64'd33);
    chk("samecyc_res", {hi, lo}, 64'd6);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; div = 1'b0; u = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_flags", {61'd0, busy, done, dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midrst_no_done", 40);
    run_op(1'b0, 1'b1, 32'd3, 32'd5, "multu_3x5");

    for (int i = 0; i < 25; i++) begin
      d  = DIV_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      uu = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(d, uu, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits (N >= 4, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request new operation; accepted only when idle.
REQ-005 SHALL have port div  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have port u  input  1  1 = unsigned, 0 = signed (two's complement).
REQ-007 SHALL have port a  input  N  multiplicand or dividend, sampled on the accepting edge.
REQ-008 SHALL have port b  input  N  multiplier or divisor, sampled on the accepting edge.
REQ-009 SHALL have port hi_we  input  1  write wdata into HI (MTHI).
REQ-010 SHALL have port lo_we  input  1  write wdata into LO (MTLO).
REQ-011 SHALL have port wdata  input  N  data for MTHI/MTLO.
REQ-012 SHALL have port hi  output  N  HI register.
REQ-013 SHALL have port lo  output  N  LO register.
REQ-014 SHALL have port busy  output  1  operation in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-017 SHALL use FSM states IDLE, CALC, FIX: IDLE->CALC on start; CALC runs exactly N iterations, then FIX; FIX->IDLE.
REQ-018 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no queuing.
REQ-019 SHALL assert busy in CALC and FIX only.
REQ-020 SHALL write hi/lo and pulse done on the FIX->IDLE edge, so done is high N+1 edges after the accepting edge, for exactly one cycle.
REQ-021 SHALL multiply radix-2 shift-add on magnitudes, then negate the 2N result in FIX when the operand signs differ (signed only): {hi,lo} = a*b.
REQ-022 SHALL divide by radix-2 restoring division on magnitudes: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-023 SHALL handle signed most-negative / -1 with lo = most-negative value and hi = 0, and no flag.
REQ-024 SHALL handle b == 0 on divide with the same latency: lo = all ones, hi = a, dz = 1; dz is otherwise 0 and held until the next done.
REQ-025 SHALL apply hi_we/lo_we only in IDLE and ignore them while busy.
REQ-026 SHALL apply a same-cycle hi_we/lo_we together with an accepted start; completion later overwrites hi/lo.
REQ-027 SHALL keep hi/lo stable during CALC/FIX, holding the previous values until completion.

Reset
REQ-028 SHALL, on rst_n low at any time (including mid-operation), force IDLE, hi=0, lo=0, busy=0, done=0, dz=0, with no pending completion.

Configuration
REQ-029 SHALL, with MDU_DIV_EN defined, provide the divide path as specified.
REQ-030 SHALL, without MDU_DIV_EN, remove the divider logic: start with div=1 is ignored (no busy, no done), and dz is tied 0.

Structure
REQ-031 SHALL place in shared package mdu_pkg: state typedef mdu_state_t and constant MDU_DEFAULT_N = 32.
REQ-032 SHALL instantiate the existing au module once, at width N+1, for the per-iteration add/subtract; no other sub-modules.

Verification
REQ-033 SHALL cover (N=32): MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001, done exactly 33 edges after start, busy low afterwards.
REQ-034 SHALL cover: MULT a=FFFFFFFE b=00000003 -> hi=FFFFFFFF lo=FFFFFFFA.
REQ-035 SHALL cover: DIV a=FFFFFFF9 b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF dz=0; DIVU same operands -> lo=7FFFFFFC hi=00000001.
REQ-036 SHALL cover: DIVU a=00000007 b=0 -> lo=FFFFFFFF hi=00000007 dz=1; without MDU_DIV_EN -> no busy, no done.
REQ-037 SHALL cover: MTHI 12345678 / MTLO 9ABCDEF0 in IDLE -> read back; the same writes while busy -> ignored; start while busy -> no second done.
REQ-038 SHALL cover: rst_n pulsed low at iteration 10 -> hi=lo=0, busy=0, no done; a new MULTU 3*5 then gives lo=0000000F hi=0.
